// File: rtl/halt_control_if.sv
// Button, CPU-halt and fed-back system clock signals between the board and the
// halt controller; slave is the controller, master is whatever drives the buttons.
interface halt_control_if;
  logic       i_btnRun;
  logic       i_btnStop;
  logic       i_btnStep;
  logic       i_cpuHalt;
  logic       i_sysClk;
  logic       o_halt;
  logic [1:0] o_state;
  logic       o_stepDone;

  modport slave (
    input  i_btnRun, i_btnStop, i_btnStep, i_cpuHalt, i_sysClk,
    output o_halt, o_state, o_stepDone
  );

  modport master (
    output i_btnRun, i_btnStop, i_btnStep, i_cpuHalt, i_sysClk,
    input  o_halt, o_state, o_stepDone
  );
endinterface

// File: rtl/halt_control.sv
// Run/stop/single-step controller gating the system clock divider from
// debounced front-panel buttons.
//
// state     | meaning
// HALTED    | system clock stopped, waiting for run or step
// RUN       | system clock free-running
// STEP_RISE | clock released, waiting for one i_sysClk rising edge
// STEP_FALL | high phase in progress, halt after the following falling edge
module halt_control #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit START_RUNNING   = 1'b0
) (
  input logic           i_clk,
  input logic           i_rst,
  halt_control_if.slave bus
);
  typedef enum logic [1:0] {
    HALTED    = 2'b00,
    RUN       = 2'b01,
    STEP_RISE = 2'b10,
    STEP_FALL = 2'b11
  } state_t;

  localparam state_t      RESET_STATE = START_RUNNING ? RUN : HALTED;
  localparam logic [15:0] DB_LAST     = 16'(DEBOUNCE_CYCLES - 1);
  localparam int          B_RUN       = 0;
  localparam int          B_STOP      = 1;
  localparam int          B_STEP      = 2;

  logic [2:0]  btn_raw;
  logic [2:0]  sync1_q, sync1_d;
  logic [2:0]  sync2_q, sync2_d;
  logic [2:0]  deb_q, deb_d;
  logic [2:0]  press_q, press_d;
  logic [15:0] cnt_q [3];
  logic [15:0] cnt_d [3];
  logic        sys_q, sys_d;
  logic        sys_rise, sys_fall;
  state_t      state_q, state_d;
  logic        halt_q, halt_d;
  logic        step_done_q, step_done_d;

  assign btn_raw = {bus.i_btnStep, bus.i_btnStop, bus.i_btnRun};

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        deb_d[i] = ~deb_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
    press_d = deb_d & ~deb_q;
  end

  assign sys_d    = bus.i_sysClk;
  assign sys_rise = bus.i_sysClk & ~sys_q;
  assign sys_fall = ~bus.i_sysClk & sys_q;

  always_comb begin
    state_d     = state_q;
    step_done_d = 1'b0;
    case (state_q)
      HALTED: begin
        if (press_q[B_STOP]) begin
          state_d = HALTED;
        end else if (!bus.i_cpuHalt) begin
          if (press_q[B_RUN]) begin
            state_d = RUN;
          end else if (press_q[B_STEP]) begin
            state_d = STEP_RISE;
          end
        end
      end
      RUN: begin
        if (press_q[B_STOP] || bus.i_cpuHalt) state_d = HALTED;
      end
      STEP_RISE: begin
        if (press_q[B_STOP]) begin
          state_d = HALTED;
        end else if (sys_rise) begin
          state_d = STEP_FALL;
        end
      end
      STEP_FALL: begin
        if (press_q[B_STOP]) begin
          state_d = HALTED;
        end else if (sys_fall) begin
          state_d     = HALTED;
          step_done_d = 1'b1;
        end
      end
      default: state_d = HALTED;
    endcase
    // registered alongside the state so o_halt always equals a decode of state_q
    halt_d = (state_d == HALTED);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      press_q     <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      sys_q       <= 1'b0;
      state_q     <= RESET_STATE;
      halt_q      <= !START_RUNNING;
      step_done_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      press_q     <= press_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      sys_q       <= sys_d;
      state_q     <= state_d;
      halt_q      <= halt_d;
      step_done_q <= step_done_d;
    end
  end

  assign bus.o_state    = state_q;
  assign bus.o_halt     = halt_q;
  assign bus.o_stepDone = step_done_q;
endmodule

// File: doc/halt_control.md
HALT_CONTROL -- requirements
Module: halt_control

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, the number of consecutive i_clk cycles a synchronized button level must hold before it is accepted (range 2..65535).
REQ-002 SHALL have parameter START_RUNNING, default 0; 1 selects RUN as the post-reset state instead of HALTED.
REQ-003 SHALL have i_clk  input  1  board clock; the only clock.
REQ-004 SHALL have i_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have i_btnRun  input  1  raw run button, active-high, asynchronous to i_clk.
REQ-006 SHALL have i_btnStop  input  1  raw stop button, active-high, asynchronous to i_clk.
REQ-007 SHALL have i_btnStep  input  1  raw single-step button, active-high, asynchronous to i_clk.
REQ-008 SHALL have i_cpuHalt  input  1  CPU has executed a halt instruction, level, synchronous to i_clk.
REQ-009 SHALL have i_sysClk  input  1  divided system clock fed back from the clock divider, sampled as data on i_clk.
REQ-010 SHALL have o_halt  output  1  halt request to the clock divider; 1 stops the system clock.
REQ-011 SHALL have o_state  output  2  current FSM state encoding, for LEDs.
REQ-012 SHALL have o_stepDone  output  1  one-cycle pulse when a single step completes.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-014 SHALL debounce each synchronized button with its own counter:
- counter clears while the synchronized level equals the debounced level;
- counter increments otherwise;
- on reaching DEBOUNCE_CYCLES-1, debounced level toggles and counter clears.
REQ-015 SHALL ignore glitches shorter than DEBOUNCE_CYCLES i_clk cycles.
REQ-016 SHALL generate a one-cycle press pulse on each 0->1 transition of a debounced level; a held button yields exactly one pulse.
REQ-017 SHALL register i_sysClk once per i_clk cycle and detect rising and falling edges against the registered value.
REQ-018 SHALL implement states HALTED=2'b00, RUN=2'b01, STEP_RISE=2'b10, STEP_FALL=2'b11; o_state equals the state register.
REQ-019 HALTED: stop press -> stay.
- Run press -> RUN.
- Otherwise step press -> STEP_RISE.
- Run and step presses are ignored while i_cpuHalt=1.
REQ-020 RUN: stop press or i_cpuHalt=1 -> HALTED on the next i_clk edge; run/step presses ignored.
REQ-021 STEP_RISE: stop press -> HALTED; otherwise i_sysClk rising edge -> STEP_FALL; i_cpuHalt ignored.
REQ-022 STEP_FALL: stop press -> HALTED, no o_stepDone; otherwise i_sysClk falling edge -> HALTED with o_stepDone=1 for exactly that one cycle.
REQ-023 Simultaneous press priority SHALL be stop > run > step.
REQ-024 o_halt SHALL be 1 exactly when the state is HALTED, decoded from the state register only; no combinational path from any input.
REQ-025 Raw button edge to o_state change SHALL take between DEBOUNCE_CYCLES+2 and DEBOUNCE_CYCLES+4 i_clk cycles.
REQ-026 A single step SHALL release exactly one rising edge of i_sysClk and SHALL keep o_halt low until after the following falling edge, so the high phase is never truncated.

Reset
REQ-027 i_rst=1 SHALL, without waiting for i_clk, set:
- state to HALTED (RUN if START_RUNNING=1);
- o_halt to 1 (0 if START_RUNNING=1);
- o_stepDone to 0;
- all synchronizer flops, debounced levels, debounce counters and the i_sysClk history register to 0.
REQ-028 Any debounce in progress SHALL be discarded at reset; a press held across reset deassertion SHALL need a full DEBOUNCE_CYCLES to be accepted.

Verification (DEBOUNCE_CYCLES=4, START_RUNNING=0)
REQ-029 Reset pulse -> o_halt=1, o_state=00, o_stepDone=0 immediately, before any i_clk edge.
REQ-030 i_btnRun high 3 cycles -> no state change; then i_btnRun held high 20 cycles -> o_state=01, o_halt=0 within 6-8 cycles of the rising edge, exactly one transition.
REQ-031 In RUN, i_cpuHalt=1 -> o_halt=1, o_state=00 next cycle; debounced run press with i_cpuHalt still 1 -> stays 00.
REQ-032 i_sysClk toggling every 8 cycles, debounced step press -> o_state 10 then 11 then 00; exactly one i_sysClk rise while o_halt=0; o_stepDone high one cycle, coincident with the return to 00.
REQ-033 Run and stop pressed together from HALTED -> stays 00; stop during STEP_RISE -> 00 with no o_stepDone pulse.
REQ-034 i_rst asserted in RUN while i_btnStop is mid-debounce -> o_halt=1 asynchronously; after release, i_btnStop still held -> no action until a further 4+ stable cycles.
